// File: rtl/imem_pkg.sv
// Shared types and the address-check helper for the instruction-memory arbiter.
package imem_pkg;

  typedef enum logic {
    BOOT,
    RUN
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    LOAD
  } owner_e;

  // Misaligned, or any byte-address bit above the word index is set.
  function automatic logic is_bad_addr(input logic [31:0] addr, input int unsigned addr_width);
    logic bad;
    bad = (addr[1:0] != 2'b00);
    for (int unsigned i = 2; i < 32; i++) begin
      if (i >= addr_width + 2 && addr[i]) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/imem_arb_grant.sv
// Fetch-priority grant with loader starvation protection; ready outputs are combinational.
module imem_arb_grant
  import imem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  arb_state_e state,
  input  logic       if_req_valid,
  input  logic       if_flush,
  input  logic       ld_req_valid,
  output logic       if_req_ready,
  output logic       ld_req_ready
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             sel_ld;

  // The loader owns the port whenever fetch is not taking it; readies stay low in reset.
  always_comb begin
    starved      = (starve_cnt == LIMIT);
    sel_ld       = (state == BOOT) || !if_req_valid || if_flush || starved;
    if_req_ready = rst_n && !sel_ld;
    ld_req_ready = rst_n && sel_ld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (sel_ld) begin
      starve_cnt <= '0;
    end else if (ld_req_valid && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction BRAM arbiter between fetch and loader/debug ports.
// Define IMEM_BOOT_HOLD_EN to hold fetch off in BOOT until ld_done.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [31:0]           if_req_addr,
  input  logic                  if_flush,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rsp_data,
  output logic                  if_rsp_err,
  input  logic                  ld_req_valid,
  output logic                  ld_req_ready,
  input  logic                  ld_req_we,
  input  logic [31:0]           ld_req_addr,
  input  logic [31:0]           ld_req_wdata,
  input  logic [3:0]            ld_req_wstrb,
  input  logic                  ld_done,
  output logic                  ld_rsp_valid,
  output logic [31:0]           ld_rsp_data,
  output logic                  ld_rsp_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q;
  logic        err_q;
  logic        wr_q;
  logic        if_acc, ld_acc, acc_bad;
  logic [31:0] acc_addr;
  logic        fetch_rsp, load_rsp;

  imem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk          (clk),
    .rst_n        (rst_n),
    .state        (state_q),
    .if_req_valid (if_req_valid),
    .if_flush     (if_flush),
    .ld_req_valid (ld_req_valid),
    .if_req_ready (if_req_ready),
    .ld_req_ready (ld_req_ready)
  );

`ifdef IMEM_BOOT_HOLD_EN
  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && ld_done) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end
`else
  logic unused_ld_done;
  assign unused_ld_done = ld_done;

  always_comb state_d = RUN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end
`endif

  // BRAM port follows whichever request was accepted this cycle.
  always_comb begin
    if_acc    = if_req_valid && if_req_ready;
    ld_acc    = ld_req_valid && ld_req_ready;
    acc_addr  = if_acc ? if_req_addr : ld_req_addr;
    acc_bad   = is_bad_addr(acc_addr, ADDR_WIDTH);
    mem_en    = (if_acc || ld_acc) && !acc_bad;
    mem_we    = (ld_acc && ld_req_we && !acc_bad) ? ld_req_wstrb : '0;
    mem_addr  = acc_addr[ADDR_WIDTH+1:2];
    mem_wdata = ld_req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= NONE;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      owner_q <= if_acc ? FETCH : (ld_acc ? LOAD : NONE);
      err_q   <= acc_bad;
      wr_q    <= ld_acc && ld_req_we;
    end
  end

  // A flush in the response cycle cancels the fetch response only.
  always_comb begin
    fetch_rsp    = (owner_q == FETCH) && !if_flush;
    load_rsp     = (owner_q == LOAD);
    if_rsp_valid = fetch_rsp;
    if_rsp_err   = fetch_rsp && err_q;
    if_rsp_data  = (fetch_rsp && !err_q) ? mem_rdata : '0;
    ld_rsp_valid = load_rsp;
    ld_rsp_err   = load_rsp && err_q;
    ld_rsp_data  = (load_rsp && !err_q && !wr_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a behavioural model predicts grants and responses.
module tb_imem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned LIMIT = 8;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef IMEM_BOOT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid, if_req_ready, if_flush;
  logic [31:0]   if_req_addr;
  logic          if_rsp_valid, if_rsp_err;
  logic [31:0]   if_rsp_data;
  logic          ld_req_valid, ld_req_ready, ld_req_we, ld_done;
  logic [31:0]   ld_req_addr, ld_req_wdata;
  logic [3:0]    ld_req_wstrb;
  logic          ld_rsp_valid, ld_rsp_err;
  logic [31:0]   ld_rsp_data;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t fq[$];
  exp_t lq[$];

  imem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_we(ld_req_we),
    .ld_req_addr(ld_req_addr), .ld_req_wdata(ld_req_wdata), .ld_req_wstrb(ld_req_wstrb),
    .ld_done(ld_done), .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
    .ld_rsp_err(ld_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  // Behavioural BRAM attached to the DUT port (read-first, byte enables).
  logic [31:0] bram [DEPTH];
  bit          bram_wr [DEPTH];
  function automatic logic [31:0] bram_rd(input logic [AW-1:0] a);
    return bram_wr[a] ? bram[a] : init_word(int'(a));
  endfunction
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= bram_rd(mem_addr);
      if (mem_we != 4'b0) begin
        bram[mem_addr]    <= merge(bram_rd(mem_addr), mem_wdata, mem_we);
        bram_wr[mem_addr] <= 1'b1;
      end
    end
  end

  // Reference model state: memory image, boot/run phase, consecutive loader denials.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_wr [DEPTH];
  bit          m_run;
  int unsigned m_wait;
  bit          pend_f;
  logic [31:0] pend_data;
  logic        pend_err;
  bit          g_f, g_l;

  function automatic logic [31:0] ref_rd(input int unsigned i);
    return ref_wr[i] ? ref_mem[i] : init_word(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_if_rsp_valid"}, 32'(if_rsp_valid), 0);
    chk({tag, "_if_rsp_data"}, if_rsp_data, 0);
    chk({tag, "_if_rsp_err"}, 32'(if_rsp_err), 0);
    chk({tag, "_ld_rsp_valid"}, 32'(ld_rsp_valid), 0);
    chk({tag, "_ld_rsp_data"}, ld_rsp_data, 0);
    chk({tag, "_ld_rsp_err"}, 32'(ld_rsp_err), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
  endtask

  task automatic step(input bit iv, input logic [31:0] ia, input bit fl,
                      input bit lv, input bit lwe, input logic [31:0] la,
                      input logic [31:0] lwd, input logic [3:0] lws, input bit done);
    bit          sel_ld, bad, exp_en;
    logic [31:0] a;
    int unsigned idx;
    @(posedge clk);
    #1;
    if_req_valid = iv; if_req_addr = ia; if_flush = fl;
    ld_req_valid = lv; ld_req_we = lwe; ld_req_addr = la;
    ld_req_wdata = lwd; ld_req_wstrb = lws; ld_done = done;
    if (pend_f) begin
      if (!fl) fq.push_back('{cyc, pend_data, pend_err});
      pend_f = 0;
    end
    // Fetch wins unless absent, flushed, booting, or the loader has waited LIMIT cycles.
    sel_ld = !m_run || !iv || fl || (m_wait >= LIMIT);
    g_f = iv && !sel_ld;
    g_l = lv && sel_ld;
    a   = g_f ? ia : la;
    bad = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0);
    idx = int'(a[AW+1:2]);
    exp_en = (g_f || g_l) && !bad;
    if (g_f) begin
      pend_f    = 1;
      pend_err  = bad;
      pend_data = bad ? 32'h0 : ref_rd(idx);
    end
    if (g_l) begin
      lq.push_back('{cyc + 1, (bad || lwe) ? 32'h0 : ref_rd(idx), bad});
      if (lwe && !bad) begin
        ref_mem[idx] = merge(ref_rd(idx), lwd, lws);
        ref_wr[idx]  = 1'b1;
      end
    end
    #1;
    chk("if_req_ready", 32'(if_req_ready), 32'(!sel_ld));
    chk("ld_req_ready", 32'(ld_req_ready), 32'(sel_ld));
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    if (exp_en) begin
      chk("mem_addr", 32'(mem_addr), idx);
      chk("mem_we", 32'(mem_we), (g_l && lwe) ? 32'(lws) : 32'h0);
    end
    if (sel_ld) m_wait = 0;
    else if (lv && m_wait < LIMIT) m_wait++;
    if (HOLD && !m_run && done) m_run = 1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] fa, la;
      fa = ($urandom_range(0, 9) < 8) ? {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00} : $urandom;
      la = ($urandom_range(0, 9) < 8) ? {20'h0, 10'($urandom_range(0, 63)), 2'b00} : $urandom;
      step($urandom_range(0, 9) < 7, fa, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, la,
           $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
    end
  endtask

  task automatic model_reset();
    m_run  = !HOLD;
    m_wait = 0;
    pend_f = 0;
  endtask

  // Monitor: pops an expectation whenever a response is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fq.size() > 0 && fq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL if_rsp_missing: got no response expected one at cycle %0d", fq[0].cyc);
        void'(fq.pop_front());
      end
      if (if_rsp_valid) begin
        if (fq.size() == 0 || fq[0].cyc != cyc) begin
          checks++; errors++;
          $display("FAIL if_rsp_unexpected: got valid with data 0x%08h expected none (cycle %0d)", if_rsp_data, cyc);
        end else begin
          exp_t e;
          e = fq.pop_front();
          chk("if_rsp_data", if_rsp_data, e.data);
          chk("if_rsp_err", 32'(if_rsp_err), 32'(e.err));
        end
      end
      if (lq.size() > 0 && lq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL ld_rsp_missing: got no response expected one at cycle %0d", lq[0].cyc);
        void'(lq.pop_front());
      end
      if (ld_rsp_valid) begin
        if (lq.size() == 0 || lq[0].cyc != cyc) begin
          checks++; errors++;
          $display("FAIL ld_rsp_unexpected: got valid with data 0x%08h expected none (cycle %0d)", ld_rsp_data, cyc);
        end else begin
          exp_t e;
          e = lq.pop_front();
          chk("ld_rsp_data", ld_rsp_data, e.data);
          chk("ld_rsp_err", 32'(ld_rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 0; if_req_valid = 0; if_req_addr = 0; if_flush = 0;
    ld_req_valid = 0; ld_req_we = 0; ld_req_addr = 0; ld_req_wdata = 0;
    ld_req_wstrb = 0; ld_done = 0;
    model_reset();
    #3 check_reset("por");
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // Boot: fetch held (when boot hold is built in), program word loaded, then ld_done.
    repeat (3) step(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h0, 32'h0050_0093, 4'hF, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Back-to-back fetches.
    step(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Starvation: loader read of 0x4 pending under continuous fetch.
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 32'(i * 4), 0, 1, 0, 32'h4, 0, 0, 0);
      if (g_l) begin
        n = i;
        break;
      end
    end
    chk("starve_grant_cycle", 32'(n), LIMIT + 1);
    step(1, 32'h40, 0, 1, 0, 32'h8, 0, 0, 0);
    idle();

    // Address errors on both ports.
    step(1, 32'h2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h3, 32'hDEAD_BEEF, 4'hF, 0);
    step(0, 0, 0, 1, 0, 32'h8000_0000, 0, 0, 0);
    idle();

    // Flush the cycle after acceptance, with a loader read pending.
    step(1, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'hC, 1, 1, 0, 32'h10, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();

    rand_steps(400);
    idle(); idle();

    // Reset the cycle after a fetch is accepted: its response must vanish.
    step(1, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 0;
    if_req_valid = 0; ld_req_valid = 0; if_flush = 0; ld_done = 0;
    model_reset();
    #1 check_reset("mid_rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    rand_steps(60);
    repeat (3) idle();
    chk("fq_drained", 32'(fq.size()), 0);
    chk("lq_drained", 32'(lq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-ported instruction BRAM between the fetch stage and a program-load/debug port. Requests arrive on valid/ready handshakes, the arbiter drives the BRAM port, and it returns registered, one-cycle-latency responses to the requester that was granted. It sits between the fetch stage and the instruction memory. It handles the boot hold-off, fetch flushes, address checking and loader starvation protection.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-index bits; memory depth is 2**ADDR_WIDTH words
- STARVE_LIMIT, 8, consecutive loader denials before the loader is forced a grant (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  32  fetch byte address
- if_flush  in  1  discard fetch response due this cycle; block fetch acceptance this cycle
- if_rsp_valid  out  1  fetch response valid
- if_rsp_data  out  32  instruction word
- if_rsp_err  out  1  misaligned or out-of-range fetch
- ld_req_valid  in  1  loader request
- ld_req_ready  out  1  loader request accepted
- ld_req_we  in  1  1 = write, 0 = read
- ld_req_addr  in  32  loader byte address
- ld_req_wdata  in  32  write data
- ld_req_wstrb  in  4  byte enables
- ld_done  in  1  single-cycle pulse: program load complete
- ld_rsp_valid  out  1  loader response (read data or write ack)
- ld_rsp_data  out  32  read data; 0 for writes
- ld_rsp_err  out  1  out-of-range or misaligned loader access
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  ADDR_WIDTH  BRAM word index
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid the cycle after mem_en

## Operation
- FSM states are BOOT and RUN.
  - Reset enters BOOT, or RUN per the Configuration section.
  - BOOT→RUN when ld_done=1. There is no transition back except by reset.
- BOOT:
  - if_req_ready=0.
  - ld_req_ready=1.
- RUN arbitration is fetch priority:
  - The loader is granted when if_req_valid=0 or if_flush=1.
  - The loader is also granted when starve_cnt==STARVE_LIMIT. In that case if_req_ready=0 that cycle.
- starve_cnt behaviour:
  - Increments, saturating, each cycle ld_req_valid=1 and fetch is granted.
  - Clears on any loader grant.
- The ready signals are combinational from the state, the valid inputs, if_flush and starve_cnt. At most one ready is high per cycle.
- Acceptance (valid&&ready) in cycle N drives the BRAM port in cycle N:
  - mem_en=1.
  - mem_addr=addr[ADDR_WIDTH+1:2].
  - mem_we=wstrb for loader writes, else 0.
- An access is in error when addr[1:0]≠0 or any of addr[31:ADDR_WIDTH+2] is nonzero:
  - mem_en=0.
  - The response carries err=1 and data=0.
- An owner register (NONE/FETCH/LOAD) plus a registered err bit record each accepted access for its N+1 response.
- if_flush=1 in cycle N+1 forces if_rsp_valid=0 for the fetch accepted in N.
- Responses cannot be backpressured. Throughput is one access per cycle, back-to-back.

## Timing
- Reset values:
  - All rsp_valid=0.
  - rsp_data=0 and err=0.
  - owner=NONE.
  - starve_cnt=0.
  - mem_en=0 and mem_we=0.
- Latency: response exactly one cycle after acceptance. Response data is mem_rdata passed through combinationally, gated to 0 on error.
- ld_done arriving while a loader access is outstanding: that response still completes. Fetch may be accepted in the same cycle as the response.
- Reset asserted mid-access: the outstanding response is dropped. No rsp_valid is produced after reset.
- if_flush with no fetch outstanding has no effect apart from if_req_ready=0.
- Simultaneous valids at the saturated limit: the loader wins. starve_cnt returns to 0 in the next cycle.

## Configuration
- IMEM_BOOT_HOLD_EN defined: reset enters BOOT, and fetch is held off until ld_done.
- IMEM_BOOT_HOLD_EN undefined:
  - Reset enters RUN directly and ld_done is ignored.
  - The BRAM is expected to be preinitialised from its .mem file.

## Structure
- imem_pkg holds:
  - arb_state_e (BOOT, RUN).
  - owner_e (NONE, FETCH, LOAD).
  - The error-check function is_bad_addr(addr, ADDR_WIDTH).
- One sub-module, imem_arb_grant: combinational grant and ready logic plus the starve_cnt register. The top level holds the FSM, the response registers and the BRAM port muxing.

## Test plan
- Reset with IMEM_BOOT_HOLD_EN defined; hold if_req_valid=1 → if_req_ready stays 0. Loader write of 0x00500093 to 0x0, then ld_done → next cycle if_req_ready=1. Fetch 0x0 → if_rsp_data=0x00500093 one cycle later.
- RUN, fetch 0x0,0x4,0x8 back-to-back → three consecutive if_rsp_valid cycles, in-order data.
- Fetch valid continuously with loader read of 0x4 pending, STARVE_LIMIT=8 → loader granted in the 9th cycle, if_req_ready=0 that cycle, ld_rsp_valid the cycle after.
- Fetch 0x2 → if_rsp_err=1, data 0, mem_en=0. Fetch 0x1000 with ADDR_WIDTH=10 → if_rsp_err=1.
- Fetch 0x8 accepted, if_flush=1 next cycle → no if_rsp_valid. A loader request pending in the flush cycle is granted.
- rst_n dropped the cycle after fetch acceptance → no response; all outputs at reset values asynchronously.
